// File: rtl/pid_ctrl_param.sv
// pid_ctrl_param
//   Two-stage, valid-pipelined PID balance controller with a soft-start ramp timer.
//   Stage 1 saturates the pitch error, updates the integrator (overflow clamp/hold and
//   conditional-integration anti-windup) and registers the P, I and D terms.
//   Stage 2 sums the terms, clamps to OUT_W and registers the output word with a strobe.
//   The soft-start counter ramps while pwr_up is high and stops at full scale.
//
// Ports
//   clk        in   1      clock
//   rst_n      in   1      asynchronous active-low reset
//   vld        in   1      ptch / ptch_rt valid this cycle
//   ptch       in   16     signed pitch error
//   ptch_rt    in   16     signed pitch rate
//   pwr_up     in   1      0 holds the soft-start counter at zero
//   rider_off  in   1      synchronous integrator clear (wins over vld)
//   PID_cntrl  out  OUT_W  signed clamped control word
//   cntrl_vld  out  1      one-cycle strobe: PID_cntrl updated
//   cntrl_sat  out  1      PID_cntrl was clamped on the last update
//   ss_tmr     out  8      soft-start ramp value
module pid_ctrl_param #(
  parameter int ERR_W    = 10,
  parameter int INT_W    = 18,
  parameter int OUT_W    = 12,
  parameter int P_COEFF  = 12,
  parameter int I_SHIFT  = 6,
  parameter int D_SHIFT  = 6,
  parameter int AW_EN    = 1,
  parameter int OV_CLAMP = 1,
  parameter int SS_W     = 27,
  parameter int FAST_SIM = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld,
  input  logic signed [15:0]      ptch,
  input  logic signed [15:0]      ptch_rt,
  input  logic                    pwr_up,
  input  logic                    rider_off,
  output logic signed [OUT_W-1:0] PID_cntrl,
  output logic                    cntrl_vld,
  output logic                    cntrl_sat,
  output logic [7:0]              ss_tmr
);

  localparam int PW   = ERR_W + 6;
  localparam int DW   = 17;
  localparam int MaxA = (INT_W > PW) ? INT_W : PW;
  localparam int MaxB = (MaxA > DW) ? MaxA : DW;
  localparam int SumW = MaxB + 2;

  localparam logic signed [5:0] PCoef = P_COEFF[5:0];

  // Saturation limits, expressed at the width they are compared against.
  localparam logic signed [15:0] PtchHi = {{(16 - ERR_W + 1){1'b0}}, {(ERR_W - 1){1'b1}}};
  localparam logic signed [15:0] PtchLo = {{(16 - ERR_W + 1){1'b1}}, {(ERR_W - 1){1'b0}}};
  localparam logic signed [ERR_W-1:0] ErrHi = {1'b0, {(ERR_W - 1){1'b1}}};
  localparam logic signed [ERR_W-1:0] ErrLo = {1'b1, {(ERR_W - 1){1'b0}}};
  localparam logic signed [INT_W-1:0] IntHi = {1'b0, {(INT_W - 1){1'b1}}};
  localparam logic signed [INT_W-1:0] IntLo = {1'b1, {(INT_W - 1){1'b0}}};
  localparam logic signed [SumW-1:0] SumHi = {{(SumW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [SumW-1:0] SumLo = {{(SumW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

  localparam logic [SS_W-1:0] TmrInc = (FAST_SIM != 0) ? {{(SS_W - 9){1'b0}}, 9'h100}
                                                       : {{(SS_W - 1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------------------------
  // Error saturation
  // ---------------------------------------------------------------------------------------------
  logic signed [ERR_W-1:0] err;

  always_comb begin
    err = ptch[ERR_W-1:0];
    if (ptch > PtchHi) begin
      err = ErrHi;
    end else if (ptch < PtchLo) begin
      err = ErrLo;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Integrator
  // ---------------------------------------------------------------------------------------------
  logic signed [INT_W-1:0] integ_q, integ_d;
  logic signed [INT_W-1:0] integ_acc;  // integrator after this sample, ignoring rider_off
  logic signed [INT_W-1:0] integ_new;  // integrator after this sample, rider_off applied
  logic signed [INT_W:0]   integ_sum;
  logic                    integ_ovf;
  logic                    freeze;

  assign integ_sum = {integ_q[INT_W-1], integ_q} + {{(INT_W + 1 - ERR_W){err[ERR_W-1]}}, err};
  assign integ_ovf = integ_sum[INT_W] != integ_sum[INT_W-1];

  // Conditional integration: stop accumulating while the output is pinned and the new error
  // would push it further into the same rail.
  assign freeze = (AW_EN != 0) && cntrl_sat && (err[ERR_W-1] == PID_cntrl[OUT_W-1]);

  always_comb begin
    integ_acc = integ_sum[INT_W-1:0];
    if (freeze) begin
      integ_acc = integ_q;
    end else if (integ_ovf) begin
      if (OV_CLAMP != 0) begin
        integ_acc = integ_sum[INT_W] ? IntLo : IntHi;
      end else begin
        integ_acc = integ_q;
      end
    end
  end

  assign integ_new = rider_off ? '0 : integ_acc;

  always_comb begin
    integ_d = integ_q;
    if (rider_off) begin
      integ_d = '0;
    end else if (vld) begin
      integ_d = integ_acc;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: term registers
  // ---------------------------------------------------------------------------------------------
  logic signed [PW-1:0]    p_val, p_q;
  logic signed [INT_W-1:0] i_q;
  logic signed [DW-1:0]    rt_ext, d_val, d_q;
  logic                    s1_vld_q;

  assign p_val  = $signed({{6{err[ERR_W-1]}}, err}) * $signed({{ERR_W{PCoef[5]}}, PCoef});
  // One guard bit so that negating the most negative rate cannot wrap.
  assign rt_ext = {ptch_rt[15], ptch_rt};
  assign d_val  = -(rt_ext >>> D_SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      integ_q  <= '0;
      p_q      <= '0;
      i_q      <= '0;
      d_q      <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      integ_q  <= integ_d;
      s1_vld_q <= vld;
      if (vld) begin
        p_q <= p_val;
        i_q <= integ_new >>> I_SHIFT;
        d_q <= d_val;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: sum, clamp, output registers
  // ---------------------------------------------------------------------------------------------
  logic signed [SumW-1:0]  sum;
  logic signed [OUT_W-1:0] out_val;
  logic                    out_sat;

  assign sum = {{(SumW - PW){p_q[PW-1]}}, p_q}
             + {{(SumW - INT_W){i_q[INT_W-1]}}, i_q}
             + {{(SumW - DW){d_q[DW-1]}}, d_q};

  always_comb begin
    out_val = sum[OUT_W-1:0];
    out_sat = 1'b0;
    if (sum > SumHi) begin
      out_val = SumHi[OUT_W-1:0];
      out_sat = 1'b1;
    end else if (sum < SumLo) begin
      out_val = SumLo[OUT_W-1:0];
      out_sat = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PID_cntrl <= '0;
      cntrl_sat <= 1'b0;
      cntrl_vld <= 1'b0;
    end else begin
      cntrl_vld <= s1_vld_q;
      if (s1_vld_q) begin
        PID_cntrl <= out_val;
        cntrl_sat <= out_sat;
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Soft-start timer
  // ---------------------------------------------------------------------------------------------
  logic [SS_W-1:0] ss_cnt_q, ss_cnt_d;
  logic            ss_full;

  // Full scale is judged on the bits above the increment so both step sizes stop without wrap.
  assign ss_full = &ss_cnt_q[SS_W-1:8];

  always_comb begin
    ss_cnt_d = ss_cnt_q;
    if (!pwr_up) begin
      ss_cnt_d = '0;
    end else if (!ss_full) begin
      ss_cnt_d = ss_cnt_q + TmrInc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_cnt_q <= '0;
    end else begin
      ss_cnt_q <= ss_cnt_d;
    end
  end

  assign ss_tmr = ss_cnt_q[SS_W-1 -: 8];

endmodule

// File: tb/tb_pid_ctrl_param.sv
// Directed bench for pid_ctrl_param. Three instances share the stimulus:
//   u_main  default parameters (anti-windup on, overflow clamp)
//   u_clmp  anti-windup off, overflow clamp, small fast soft-start counter
//   u_hold  anti-windup off, overflow hold
module tb_pid_ctrl_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic signed [15:0] ptch = '0;
  logic signed [15:0] ptch_rt = '0;
  logic pwr_up = 1'b0;
  logic rider_off = 1'b0;

  logic signed [11:0] pid_m, pid_c, pid_h;
  logic vld_m, vld_c, vld_h;
  logic sat_m, sat_c, sat_h;
  logic [7:0] tmr_m, tmr_c, tmr_h;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pid_ctrl_param u_main (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt), .pwr_up(pwr_up),
    .rider_off(rider_off), .PID_cntrl(pid_m), .cntrl_vld(vld_m), .cntrl_sat(sat_m),
    .ss_tmr(tmr_m)
  );

  pid_ctrl_param #(.AW_EN(0), .OV_CLAMP(1), .SS_W(16), .FAST_SIM(1)) u_clmp (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt), .pwr_up(pwr_up),
    .rider_off(rider_off), .PID_cntrl(pid_c), .cntrl_vld(vld_c), .cntrl_sat(sat_c),
    .ss_tmr(tmr_c)
  );

  pid_ctrl_param #(.AW_EN(0), .OV_CLAMP(0)) u_hold (
    .clk(clk), .rst_n(rst_n), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt), .pwr_up(pwr_up),
    .rider_off(rider_off), .PID_cntrl(pid_h), .cntrl_vld(vld_h), .cntrl_sat(sat_h),
    .ss_tmr(tmr_h)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) cyc();
    check("reset_pid", pid_m, 0);
    check("reset_vld", vld_m, 0);
    check("reset_sat", sat_m, 0);
    check("reset_integ", u_main.integ_q, 0);
    check("reset_tmr", tmr_c, 0);
    rst_n = 1'b1;
    cyc();

    // T1: single sample, P=1200, I=100>>>6=1
    vld = 1'b1; ptch = 16'sd100;
    cyc();
    vld = 1'b0;
    check("t1_integ", u_main.integ_q, 100);
    check("t1_vld_early", vld_m, 0);
    cyc();
    check("t1_pid", pid_m, 1201);
    check("t1_vld", vld_m, 1);
    check("t1_sat", sat_m, 0);
    cyc();
    check("t1_vld_drop", vld_m, 0);
    check("t1_pid_hold", pid_m, 1201);

    // rider_off without vld clears the integrator
    rider_off = 1'b1;
    cyc();
    rider_off = 1'b0;
    check("clr_novld_m", u_main.integ_q, 0);
    check("clr_novld_c", u_clmp.integ_q, 0);

    // T3: derivative term only
    ptch = 16'sd0; ptch_rt = 16'sd6400; vld = 1'b1;
    cyc();
    vld = 1'b0;
    cyc();
    check("t3_pid", pid_m, -100);
    check("t3_integ", u_main.integ_q, 0);
    ptch_rt = 16'sh8000; vld = 1'b1;
    cyc();
    vld = 1'b0; ptch_rt = 16'sd0;
    cyc();
    check("t3_dmin_pid", pid_m, 512);
    check("t3_dmin_sat", sat_m, 0);

    // T2: back-to-back error saturation in both directions
    vld = 1'b1; ptch = 16'sh0400;
    cyc();
    check("t2_err_hi_integ", u_main.integ_q, 511);
    ptch = 16'shF830;
    cyc();
    check("t2_pid_hi", pid_m, 2047);
    check("t2_sat_hi", sat_m, 1);
    check("t2_vld_hi", vld_m, 1);
    vld = 1'b0; ptch = 16'sd0;
    cyc();
    check("t2_pid_lo", pid_m, -2048);
    check("t2_sat_lo", sat_m, 1);
    check("t2_vld_lo", vld_m, 1);
    check("t2_integ", u_main.integ_q, -1);

    // rider_off has priority over vld; I term sees the cleared integrator
    rider_off = 1'b1; vld = 1'b1; ptch = 16'sd100;
    cyc();
    rider_off = 1'b0; vld = 1'b0;
    check("clr_vld_integ", u_main.integ_q, 0);
    check("clr_vld_integ_h", u_hold.integ_q, 0);
    cyc();
    check("clr_vld_pid", pid_m, 1200);
    check("clr_vld_sat", sat_m, 0);

    // T4/T5: long run at max error
    ptch = 16'sd511; vld = 1'b1;
    repeat (600) cyc();
    check("t4_aw_integ", u_main.integ_q, 1022);
    check("t4_pid", pid_m, 2047);
    check("t4_sat", sat_m, 1);
    check("t5_clamp_integ", u_clmp.integ_q, 131071);
    check("t5_hold_integ", u_hold.integ_q, 130816);
    ptch = -16'sd100;
    cyc();
    vld = 1'b0; ptch = 16'sd0;
    check("t4_unfreeze_integ", u_main.integ_q, 922);
    check("t5_clamp_dec", u_clmp.integ_q, 130971);
    check("t5_hold_dec", u_hold.integ_q, 130716);
    cyc();
    check("t4_pid_after", pid_m, -1186);
    check("t4_sat_after", sat_m, 0);
    check("t5_clamp_pid", pid_c, 846);
    check("t5_hold_pid", pid_h, 842);
    repeat (3) cyc();
    check("idle_vld", vld_m, 0);
    check("idle_pid_hold", pid_m, -1186);

    // T6: soft-start ramp on the fast counter
    check("t6_tmr_off", tmr_c, 0);
    pwr_up = 1'b1;
    repeat (10) cyc();
    check("t6_tmr_10", tmr_c, 10);
    repeat (300) cyc();
    check("t6_tmr_full", tmr_c, 255);
    pwr_up = 1'b0;
    cyc();
    check("t6_tmr_drop", tmr_c, 0);
    pwr_up = 1'b1;
    repeat (20) cyc();
    check("t6_tmr_20", tmr_c, 20);

    // Reset mid-pipeline and mid-ramp
    vld = 1'b1; ptch = 16'sd100;
    cyc();
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tmr", tmr_c, 0);
    check("rst_pid", pid_m, 0);
    check("rst_integ", u_main.integ_q, 0);
    pwr_up = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("rst_no_vld", vld_m, 0);
    end
    check("rst_pid_after", pid_m, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
